// File: rtl/mealy_pkg.sv
// Shared definitions for the Mealy recognizer and its match reporter.
//   - Reporter FSM state encoding (2-bit, legacy-compatible constants).
//   - Input symbol constants for the two-bit recognizer alphabet, so the
//     recognizer and any bench driving it agree on the symbol values.
package mealy_pkg;

  // Reporter FSM states
  localparam logic [1:0] R_IDLE  = 2'd0;  // nothing pending, timer idle
  localparam logic [1:0] R_ACCUM = 2'd1;  // matches pending, timer running
  localparam logic [1:0] R_REQ   = 2'd2;  // report raised, waiting for ack=1
  localparam logic [1:0] R_DROP  = 2'd3;  // req dropped, waiting for ack=0

  // Recognizer input symbols
  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

endpackage

// File: rtl/mealy_match_reporter_if.sv
// Match-strobe / report-handshake bundle between the recognizer side, the
// reporter and the host.
//   Z        : match strobe into the reporter
//   ack      : host acknowledge (four-phase)
//   req      : report valid from the reporter
//   count    : reported match count (W bits)
//   overflow : reported count saturated
// Modports:
//   master : drives Z and ack, observes the report (recognizer + host side)
//   slave  : the reporter itself
interface mealy_match_reporter_if #(
  parameter int W = 8
);
  logic         Z;
  logic         ack;
  logic         req;
  logic [W-1:0] count;
  logic         overflow;

  modport master (
    output Z,
    output ack,
    input  req,
    input  count,
    input  overflow
  );

  modport slave (
    input  Z,
    input  ack,
    output req,
    output count,
    output overflow
  );
endinterface

// File: rtl/mealy_match_reporter_sat_counter.sv
// Saturating up-counter with sticky saturation flag.
//   clk, rst : clock and synchronous active-high reset
//   inc      : add one this edge (held at all-ones once full)
//   clr      : clear count and flag this edge; any inc on that edge is dropped
//   nxt      : value the counter takes this edge if clr is low
//   nxt_sat  : sticky flag value this edge if clr is low
// The look-ahead outputs let the owner latch "count including this edge"
// on the same edge it clears the counter.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] nxt,
  output logic         nxt_sat
);

  logic [W-1:0] value;
  logic         sat;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic i);
    if (&v) return v;
    return v + {{(W-1){1'b0}}, i};
  endfunction

  // A match arriving at the all-ones value is the one that gets lost.
  assign nxt     = sat_inc(value, inc);
  assign nxt_sat = sat | (inc & (&value));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      sat   <= 1'b0;
    end else begin
      value <= nxt;
      sat   <= nxt_sat;
    end
  end

endmodule

// File: rtl/mealy_match_reporter.sv
// Match reporter: counts recognizer Z strobes and hands latched counts to a
// host over a four-phase req/ack handshake. A report is latched when the
// pending count reaches THRESH or when TIMEOUT-1 edges have passed since
// the report window opened.
//   Ck    : clock, rising edge
//   reset : synchronous active-high, clears all state
//   bus   : slave side of mealy_match_reporter_if (Z, ack in; req, count,
//           overflow out, all outputs registered)
// Parameters: W (count width), THRESH (1..2^W-1), TIMEOUT (>=2).
module mealy_match_reporter
  import mealy_pkg::*;
#(
  parameter int W       = 8,
  parameter int THRESH  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  Ck,
  input  logic                  reset,
  mealy_match_reporter_if.slave bus
);

  localparam int           TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
  localparam logic [W-1:0]  THRESH_W = W'(THRESH);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          req_q;
  logic [W-1:0]  count_q;
  logic          ovf_q;

  logic [W-1:0]  acc_nxt;
  logic          sat_nxt;
  logic          latch;

  // Matches are counted in every state; only the latch edge clears acc,
  // and the Z of that edge goes into the latched count instead.
  sat_counter #(.W(W)) u_acc (
    .clk     (Ck),
    .rst     (reset),
    .inc     (bus.Z),
    .clr     (latch),
    .nxt     (acc_nxt),
    .nxt_sat (sat_nxt)
  );

  // Latching is only possible while no report is outstanding. In IDLE acc
  // is zero, so the threshold test only fires there when THRESH is 1.
  always_comb begin
    latch = 1'b0;
    case (state)
      R_IDLE:  latch = (acc_nxt >= THRESH_W);
      R_ACCUM: latch = (acc_nxt >= THRESH_W) || (timer == TMAX);
      default: latch = 1'b0;
    endcase
  end

  always_ff @(posedge Ck) begin
    if (reset) begin
      state   <= R_IDLE;
      timer   <= '0;
      req_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (latch) begin
      count_q <= acc_nxt;
      ovf_q   <= sat_nxt;
      req_q   <= 1'b1;
      timer   <= '0;
      state   <= R_REQ;
    end else begin
      case (state)
        R_IDLE: begin
          if (bus.Z) begin
            timer <= TW'(1);
            state <= R_ACCUM;
          end
        end
        R_ACCUM: begin
          timer <= timer + 1'b1;
        end
        R_REQ: begin
          if (bus.ack) begin
            req_q <= 1'b0;
            state <= R_DROP;
          end
        end
        default: begin  // R_DROP
          // Decide on the count including this edge's Z, so a match that
          // lands on the release edge still opens a window. A backlog at
          // or above THRESH latches on the next edge from ACCUM.
          if (!bus.ack) begin
            if (acc_nxt != '0) begin
              timer <= TW'(1);
              state <= R_ACCUM;
            end else begin
              state <= R_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.req      = req_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule
